// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: count/pointer widths and parameter legality.
// Latency: n/a (constant functions only, evaluated at elaboration).
// Backpressure: n/a.
package fifo_pkg;

    // Width needed to hold an occupancy in 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address depth entries; never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_legal(input int width, input int depth,
                                        input int showahead, input int ae_th,
                                        input int af_th);
        return (width >= 1) && (depth >= 2) &&
               (showahead == 0 || showahead == 1) &&
               (ae_th >= 0) && (ae_th <= depth) &&
               (af_th >= 0) && (af_th <= depth);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH wrapping pointer used for both the read and write side of the FIFO.
// Latency: advances one step on the clock edge where inc is high.
// Backpressure: none; the caller gates inc with its own accept condition.
// Ports: clk, reset (async, active-high), clear (sync flush to 0), inc, ptr.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            // Explicit wrap so non power-of-two depths work.
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with occupancy, almost flags, error pulses and FWFT/registered read.
// Latency: write visible on rdata one cycle later (showahead); registered read returns data one cycle after read.
// Backpressure: writes dropped when full (overflow pulse), reads dropped when empty (underflow pulse).
// Ports: clk, reset (async, active-high), clear (sync flush), wdata/write, read,
//        rdata/rvalid, usedw, empty/full/almost_empty/almost_full, overflow/underflow.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int SHOWAHEAD = 1,
    parameter int AE_TH     = 1,
    parameter int AF_TH     = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          write,
    input  logic                          read,
    output logic [WIDTH-1:0]              rdata,
    output logic                          rvalid,
    output logic [count_width(DEPTH)-1:0] usedw,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_TH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);

    if (!params_legal(WIDTH, DEPTH, SHOWAHEAD, AE_TH, AF_TH)) begin : g_bad_params
        $error("sync_fifo_ext: illegal parameter combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come straight from the registered count, so they lag events by one cycle.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);
    assign usedw        = count;

    // Acceptance uses pre-edge state: at full a paired write loses, at empty a paired read loses.
    assign wr_acc = write & ~full  & ~clear;
    assign rd_acc = read  & ~empty & ~clear;

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= write & full;
            underflow <= read & empty;
        end
    end

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    if (SHOWAHEAD == 1) begin : g_fwft
        assign rdata  = mem[rd_ptr];
        assign rvalid = ~empty;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                // rd_acc is already low during clear, so rvalid drops and rdata holds.
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem[rd_ptr];
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 8: number of entries, at least 2, any integer (a power of two is not required).
REQ-003 Parameter SHOWAHEAD, default 1: 1 = first-word-fall-through read; 0 = registered read with rvalid.
REQ-004 Parameter AE_TH, default 1: almost-empty threshold, range 0..DEPTH.
REQ-005 Parameter AF_TH, default DEPTH-1: almost-full threshold, range 0..DEPTH.
REQ-006 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port clear, input, 1: synchronous flush.
REQ-009 Port wdata, input, WIDTH: write data.
REQ-010 Port write, input, 1: write request.
REQ-011 Port read, input, 1: read request.
REQ-012 Port rdata, output, WIDTH: read data.
REQ-013 Port rvalid, output, 1: rdata valid; meaningful only when SHOWAHEAD=0.
REQ-014 Port usedw, output, $clog2(DEPTH+1): current number of stored entries.
REQ-015 Ports empty, full, almost_empty, almost_full: outputs, 1 bit each, status flags.
REQ-016 Ports overflow, underflow: outputs, 1 bit each, error pulses.

Function
REQ-017 A write is accepted when write=1 and full=0; a read is accepted when read=1 and empty=0.
REQ-018 An accepted write stores wdata at wr_ptr; wr_ptr advances, wrapping from DEPTH-1 to 0.
REQ-019 An accepted read advances rd_ptr, wrapping from DEPTH-1 to 0.
REQ-020 The registered count updates each cycle as count + accepted write - accepted read; it never leaves the range 0..DEPTH.
REQ-021 Flags and usedw derive combinationally from the registered count, so they reflect an event on the cycle after it.
- empty = (count==0)
- full = (count==DEPTH)
- almost_empty = (count<=AE_TH)
- almost_full = (count>=AF_TH)
REQ-022 When full, simultaneous write and read: read accepted, write rejected, overflow raised.
REQ-023 When empty, simultaneous write and read: write accepted, read rejected, underflow raised.
REQ-024 With 0<count<DEPTH, simultaneous write and read are both accepted and the count is unchanged.
REQ-025 overflow is a one-cycle registered pulse, asserted the cycle after any rejected write.
REQ-026 underflow is a one-cycle registered pulse, asserted the cycle after any rejected read.
REQ-027 SHOWAHEAD=1: rdata = mem[rd_ptr] combinationally; the word is valid while empty=0.
REQ-028 SHOWAHEAD=1: a word written into an empty FIFO appears on rdata the cycle after the write.
REQ-029 SHOWAHEAD=0: an accepted read loads mem[rd_ptr] into an rdata register and asserts rvalid on the next cycle for exactly one cycle.
REQ-030 SHOWAHEAD=0: rdata holds its value until the next accepted read.
REQ-031 SHOWAHEAD=1: rvalid = ~empty.
REQ-032 clear=1 on a clock edge sets pointers, count, rvalid, overflow and underflow to 0.
REQ-033 clear overrides a simultaneous write or read: no write, no read, no error pulse.
REQ-034 Memory contents are not cleared by clear or reset.

Reset
REQ-035 Asserting reset immediately forces:
- rd_ptr=0, wr_ptr=0, count=0
- empty=1, full=0, almost_empty=1, almost_full=(AF_TH==0)
- overflow=0, underflow=0, rvalid=0
- rdata register=0 (SHOWAHEAD=0 only)
REQ-036 Reset asserted mid-operation discards all stored entries; the first accepted write after deassertion lands at address 0.

Structure
REQ-037 Package fifo_pkg holds the constant function for count width, $clog2(DEPTH+1).
REQ-038 Package fifo_pkg holds the parameter legality checks.
REQ-039 Sub-module fifo_ptr is a modulo-DEPTH wrapping pointer with increment enable, clear and async reset; it is instantiated twice (read and write pointers).
REQ-040 Storage is a plain array inferable as RAM, with no reset on the array.

Verification (DEPTH=6, WIDTH=8, AE_TH=1, AF_TH=5 unless noted)
REQ-041 Fill test, SHOWAHEAD=1: write 0x10..0x15 on consecutive cycles -> usedw steps 1..6; almost_full at usedw=5; full at usedw=6; a 7th write raises overflow for one cycle and usedw stays 6.
REQ-042 Drain and underflow: from full, read 7 consecutive cycles -> rdata sequence 0x10..0x15; empty after the 6th read; underflow pulses once for the 7th read.
REQ-043 Wrap-around: run 20 cycles of simultaneous write and read with usedw=3 -> usedw stays 3, data order is preserved, and both pointers pass through 5->0 at least three times.
REQ-044 Edge collisions: write+read together at full -> usedw 6->5 and overflow=1; write+read together at empty -> usedw 0->1 and underflow=1.
REQ-045 SHOWAHEAD=0: write 0xA5, then read -> rvalid=1 and rdata=0xA5 one cycle after the read; rdata holds 0xA5 afterwards.
REQ-046 clear and reset: clear with usedw=4 together with write -> usedw=0, empty=1 next cycle; async reset mid-burst -> flags return to reset values before the next clk edge.
